// File: rtl/cpu5_decode_queue_pkg.sv
// rtl/cpu5_decode_queue_pkg.sv - shared encodings and bundle types for the cpu5 decode queue
//
// Purpose: branch/immediate/ALU-op encodings, RV32I opcodes, the decoded
//          control bundle and the stored queue entry layout.
// Ports:   none (package).
package cpu5_decode_queue_pkg;

  localparam int CPU5_ALUOP_W = 4;

  localparam logic [2:0] CPU5_BRANCHTYPE_NOBRANCH = 3'd0;
  localparam logic [2:0] CPU5_BRANCHTYPE_BEQ      = 3'd1;
  localparam logic [2:0] CPU5_BRANCHTYPE_BNE      = 3'd2;
  localparam logic [2:0] CPU5_BRANCHTYPE_BLT      = 3'd3;
  localparam logic [2:0] CPU5_BRANCHTYPE_BGE      = 3'd4;
  localparam logic [2:0] CPU5_BRANCHTYPE_BLTU     = 3'd5;
  localparam logic [2:0] CPU5_BRANCHTYPE_BGEU     = 3'd6;

  localparam logic [2:0] CPU5_IMMTYPE_R = 3'd0;
  localparam logic [2:0] CPU5_IMMTYPE_I = 3'd1;
  localparam logic [2:0] CPU5_IMMTYPE_S = 3'd2;
  localparam logic [2:0] CPU5_IMMTYPE_B = 3'd3;
  localparam logic [2:0] CPU5_IMMTYPE_U = 3'd4;
  localparam logic [2:0] CPU5_IMMTYPE_J = 3'd5;

  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_ADD   = 4'd0;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_SUB   = 4'd1;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_SLL   = 4'd2;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_SLT   = 4'd3;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_SLTU  = 4'd4;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_XOR   = 4'd5;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_SRL   = 4'd6;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_SRA   = 4'd7;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_OR    = 4'd8;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_AND   = 4'd9;
  localparam logic [CPU5_ALUOP_W-1:0] CPU5_ALUOP_PASSB = 4'd10;

  localparam logic [6:0] CPU5_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] CPU5_OP_STORE  = 7'b0100011;
  localparam logic [6:0] CPU5_OP_OP     = 7'b0110011;
  localparam logic [6:0] CPU5_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] CPU5_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] CPU5_OP_JALR   = 7'b1100111;
  localparam logic [6:0] CPU5_OP_JAL    = 7'b1101111;
  localparam logic [6:0] CPU5_OP_LUI    = 7'b0110111;
  localparam logic [6:0] CPU5_OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic                    memtoreg;
    logic                    memwrite;
    logic                    alusrc;
    logic                    regwrite;
    logic                    jump;
    logic [2:0]              branchtype;
    logic [CPU5_ALUOP_W-1:0] aluop;
    logic [2:0]              immtype;
    logic                    illegal;
  } cpu5_ctrl_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    cpu5_ctrl_t ctrl;
  } cpu5_bundle_t;

  localparam int CPU5_BUNDLE_W = $bits(cpu5_bundle_t);

  // alt selects SUB/SRA over ADD/SRL (funct7[5] for register ops)
  function automatic logic [CPU5_ALUOP_W-1:0] cpu5_alu_op(input logic [2:0] f3, input logic alt);
    logic [CPU5_ALUOP_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? CPU5_ALUOP_SUB : CPU5_ALUOP_ADD;
      3'b001:  op = CPU5_ALUOP_SLL;
      3'b010:  op = CPU5_ALUOP_SLT;
      3'b011:  op = CPU5_ALUOP_SLTU;
      3'b100:  op = CPU5_ALUOP_XOR;
      3'b101:  op = alt ? CPU5_ALUOP_SRA : CPU5_ALUOP_SRL;
      3'b110:  op = CPU5_ALUOP_OR;
      default: op = CPU5_ALUOP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu5_decode_queue_if.sv
// rtl/cpu5_decode_queue_if.sv - fetch/execute handshake bundle for the cpu5 decode queue
//
// Purpose: groups the enqueue side, dequeue side, flush and occupancy.
// Modports:
//   slave  - the queue: takes flush/in_*/out_ready, drives in_ready/out_*/count
//   master - the surrounding pipeline: the opposite directions
interface cpu5_decode_queue_if
  import cpu5_decode_queue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int ALUOP_W = CPU5_ALUOP_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [XLEN-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [4:0]         out_rs1;
  logic [4:0]         out_rs2;
  logic [4:0]         out_rd;
  logic [2:0]         out_funct3;
  logic               out_memtoreg;
  logic               out_memwrite;
  logic               out_alusrc;
  logic               out_regwrite;
  logic               out_jump;
  logic [2:0]         out_branchtype;
  logic [ALUOP_W-1:0] out_aluop;
  logic [2:0]         out_immtype;
  logic               out_illegal;
  logic [CNT_W-1:0]   count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3,
           out_memtoreg, out_memwrite, out_alusrc, out_regwrite, out_jump,
           out_branchtype, out_aluop, out_immtype, out_illegal, count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_funct3,
           out_memtoreg, out_memwrite, out_alusrc, out_regwrite, out_jump,
           out_branchtype, out_aluop, out_immtype, out_illegal, count
  );

endinterface

// File: rtl/cpu5_maindec_rv32i.sv
// rtl/cpu5_maindec_rv32i.sv - combinational RV32I main decoder
//
// Purpose: maps a 32-bit instruction word to the control bundle and an
//          illegal flag. Illegal words produce an all-zero control bundle.
// Ports:
//   instr_i  in   32  instruction word
//   ctrl_o   out  cpu5_ctrl_t  decoded controls + illegal
module cpu5_maindec_rv32i
  import cpu5_decode_queue_pkg::*;
(
  input  logic [31:0] instr_i,
  output cpu5_ctrl_t  ctrl_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  cpu5_ctrl_t c;
  logic       legal;

  always_comb begin
    c     = '0;
    legal = 1'b0;
    case (opcode)
      CPU5_OP_OP: begin
        legal      = (f7 == 7'b0000000) ||
                     ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        c.regwrite = 1'b1;
        c.aluop    = cpu5_alu_op(f3, f7[5]);
        c.immtype  = CPU5_IMMTYPE_R;
      end
      CPU5_OP_OPIMM: begin
        // Only the shift-immediates constrain imm[11:5]; ADDI has no SUB form.
        case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = cpu5_alu_op(f3, (f3 == 3'b101) && f7[5]);
        c.immtype  = CPU5_IMMTYPE_I;
      end
      CPU5_OP_LOAD: begin
        legal      = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                     (f3 == 3'b100) || (f3 == 3'b101);
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = CPU5_ALUOP_ADD;
        c.immtype  = CPU5_IMMTYPE_I;
      end
      CPU5_OP_STORE: begin
        legal      = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = CPU5_ALUOP_ADD;
        c.immtype  = CPU5_IMMTYPE_S;
      end
      CPU5_OP_BRANCH: begin
        legal     = (f3 != 3'b010) && (f3 != 3'b011);
        c.aluop   = CPU5_ALUOP_SUB;
        c.immtype = CPU5_IMMTYPE_B;
        case (f3)
          3'b000:  c.branchtype = CPU5_BRANCHTYPE_BEQ;
          3'b001:  c.branchtype = CPU5_BRANCHTYPE_BNE;
          3'b100:  c.branchtype = CPU5_BRANCHTYPE_BLT;
          3'b101:  c.branchtype = CPU5_BRANCHTYPE_BGE;
          3'b110:  c.branchtype = CPU5_BRANCHTYPE_BLTU;
          3'b111:  c.branchtype = CPU5_BRANCHTYPE_BGEU;
          default: c.branchtype = CPU5_BRANCHTYPE_NOBRANCH;
        endcase
      end
      CPU5_OP_JALR: begin
        legal      = (f3 == 3'b000);
        c.jump     = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = CPU5_ALUOP_ADD;
        c.immtype  = CPU5_IMMTYPE_I;
      end
      CPU5_OP_JAL: begin
        legal      = 1'b1;
        c.jump     = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = CPU5_ALUOP_ADD;
        c.immtype  = CPU5_IMMTYPE_J;
      end
      CPU5_OP_LUI: begin
        legal      = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = CPU5_ALUOP_PASSB;
        c.immtype  = CPU5_IMMTYPE_U;
      end
      CPU5_OP_AUIPC: begin
        legal      = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = CPU5_ALUOP_ADD;
        c.immtype  = CPU5_IMMTYPE_U;
      end
      default: legal = 1'b0;
    endcase

    // Compressed encodings (instr[1:0] != 11) never reach a legal opcode,
    // but the check is kept explicit so the opcode table cannot leak them.
    if (instr_i[1:0] != 2'b11) begin
      legal = 1'b0;
    end

    if (!legal) begin
      c = '0;
    end
    c.illegal = !legal;
  end

  assign ctrl_o = c;

endmodule

// File: rtl/cpu5_decode_queue.sv
// rtl/cpu5_decode_queue.sv - RV32I decode stage with a DEPTH-entry bundle FIFO
//
// Purpose: decodes each fetched word at enqueue and queues the decoded bundle
//          (pc + register fields + controls) for execute; flush empties it.
// Ports:
//   clk     in  1   clock
//   resetn  in  1   asynchronous active-low reset
//   q       cpu5_decode_queue_if.slave
//           in_valid/in_ready/in_instr/in_pc   fetch side
//           out_valid/out_ready/out_*          execute side (head entry)
//           flush                              redirect, empties the queue
//           count                              occupancy
module cpu5_decode_queue
  import cpu5_decode_queue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int ALUOP_W = CPU5_ALUOP_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  cpu5_decode_queue_if.slave   q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  cpu5_bundle_t     mem_q    [DEPTH];
  logic [XLEN-1:0]  pc_mem_q [DEPTH];

  cpu5_ctrl_t       dec_ctrl;
  cpu5_bundle_t     enq_bundle;
  cpu5_bundle_t     head;
  logic [XLEN-1:0]  head_pc;

  logic in_ready;
  logic out_valid;
  logic enq;
  logic deq;

  cpu5_maindec_rv32i u_maindec (
    .instr_i (q.in_instr),
    .ctrl_o  (dec_ctrl)
  );

  always_comb begin
    enq_bundle        = '0;
    enq_bundle.rs1    = q.in_instr[19:15];
    enq_bundle.rs2    = q.in_instr[24:20];
    enq_bundle.rd     = q.in_instr[11:7];
    enq_bundle.funct3 = q.in_instr[14:12];
    enq_bundle.ctrl   = dec_ctrl;
  end

  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready  = (count_q < DEPTH_C) || q.out_ready;
  assign out_valid = (count_q != '0);
  assign enq       = q.in_valid && in_ready && !q.flush;
  assign deq       = out_valid && q.out_ready && !q.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every visible output is masked by out_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q]    <= enq_bundle;
      pc_mem_q[wr_ptr_q] <= q.in_pc;
    end
  end

  always_comb begin
    head    = '0;
    head_pc = '0;
    if (out_valid) begin
      head    = mem_q[rd_ptr_q];
      head_pc = pc_mem_q[rd_ptr_q];
    end
  end

  assign q.in_ready       = in_ready;
  assign q.out_valid      = out_valid;
  assign q.out_pc         = head_pc;
  assign q.out_rs1        = head.rs1;
  assign q.out_rs2        = head.rs2;
  assign q.out_rd         = head.rd;
  assign q.out_funct3     = head.funct3;
  assign q.out_memtoreg   = head.ctrl.memtoreg;
  assign q.out_memwrite   = head.ctrl.memwrite;
  assign q.out_alusrc     = head.ctrl.alusrc;
  assign q.out_regwrite   = head.ctrl.regwrite;
  assign q.out_jump       = head.ctrl.jump;
  assign q.out_branchtype = head.ctrl.branchtype;
  assign q.out_aluop      = ALUOP_W'(head.ctrl.aluop);
  assign q.out_immtype    = head.ctrl.immtype;
  assign q.out_illegal    = head.ctrl.illegal;
  assign q.count          = count_q;

endmodule

// File: tb/tb_cpu5_decode_queue.sv
// tb/tb_cpu5_decode_queue.sv - scoreboard bench for cpu5_decode_queue
module tb_cpu5_decode_queue;
  import cpu5_decode_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cpu5_decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .ALUOP_W(4)) q ();

  cpu5_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ALUOP_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (q)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  f3;
    logic        mtr;
    logic        mw;
    logic        as;
    logic        rw;
    logic        j;
    logic [2:0]  br;
    logic [3:0]  alu;
    logic [2:0]  imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t mon_a;
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [2:0] f3,
                              input logic mtr, input logic mw, input logic as,
                              input logic rw, input logic j, input logic [2:0] br,
                              input logic [3:0] alu, input logic [2:0] imm,
                              input logic ill);
    exp_t e;
    e.pc = pc; e.f3 = f3; e.mtr = mtr; e.mw = mw; e.as = as; e.rw = rw;
    e.j = j; e.br = br; e.alu = alu; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.pc = q.out_pc; a.f3 = q.out_funct3; a.mtr = q.out_memtoreg;
    a.mw = q.out_memwrite; a.as = q.out_alusrc; a.rw = q.out_regwrite;
    a.j = q.out_jump; a.br = q.out_branchtype; a.alu = q.out_aluop;
    a.imm = q.out_immtype; a.ill = q.out_illegal;
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    q.in_valid = 1'b1;
    q.in_instr = instr;
    q.in_pc    = pc;
    while (!done) begin
      @(negedge clk);
      if (q.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end else begin
        n++;
        if (n > 20) begin
          checks++;
          errors++;
          $display("FAIL push_timeout pc %h: in_ready got 0 expected 1", pc);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    q.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || q.count != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_count", 64'(q.count), 64'(0));
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (resetn && q.out_valid && q.out_ready && !q.flush) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got pc %h expected no entry", q.out_pc);
          end else begin
            mon_e = sb.pop_front();
            mon_a = actual();
            // Only control bits are defined for illegal words; alu/imm are don't-care.
            if (mon_e.ill) begin
              mon_e.alu = '0; mon_e.imm = '0;
              mon_a.alu = '0; mon_a.imm = '0;
            end
            chk($sformatf("bundle_pc%0h", mon_e.pc), 64'(mon_a), 64'(mon_e));
          end
        end
      end
    join_none

    q.flush = 1'b0; q.in_valid = 1'b0; q.in_instr = '0; q.in_pc = '0; q.out_ready = 1'b0;

    #12;
    chk("rst_out_valid", 64'(q.out_valid), 64'(0));
    chk("rst_count", 64'(q.count), 64'(0));
    chk("rst_in_ready", 64'(q.in_ready), 64'(1));
    chk("rst_out_pc", 64'(q.out_pc), 64'(0));
    chk("rst_out_regwrite", 64'(q.out_regwrite), 64'(0));
    @(posedge clk); #1 resetn = 1'b1;

    // 1: addi then sub
    q.out_ready = 1'b1;
    push(32'h00500093, 32'h100, mk(32'h100, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    push(32'h402081B3, 32'h104, mk(32'h104, 3'b000, 0, 0, 0, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_SUB, CPU5_IMMTYPE_R, 0));
    drain();

    // 2: lw, blt, jal
    push(32'h0000A103, 32'h200, mk(32'h200, 3'b010, 1, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    push(32'h0020C463, 32'h204, mk(32'h204, 3'b100, 0, 0, 0, 0, 0, CPU5_BRANCHTYPE_BLT, CPU5_ALUOP_SUB, CPU5_IMMTYPE_B, 0));
    push(32'h008000EF, 32'h208, mk(32'h208, 3'b000, 0, 0, 0, 1, 1, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_J, 0));
    drain();

    // 3: fill, then simultaneous deq+enq when full
    q.out_ready = 1'b0;
    push(NOP, 32'h0, mk(32'h0, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    push(NOP, 32'h4, mk(32'h4, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    chk("full_count", 64'(q.count), 64'(DEPTH));
    chk("full_in_ready", 64'(q.in_ready), 64'(0));
    q.out_ready = 1'b1;
    push(NOP, 32'h8, mk(32'h8, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    chk("full_deq_enq_count", 64'(q.count), 64'(DEPTH));
    drain();

    // 4: flush with both handshakes asserted
    q.out_ready = 1'b0;
    push(NOP, 32'h10, mk(32'h10, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    push(NOP, 32'h14, mk(32'h14, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    chk("preflush_count", 64'(q.count), 64'(2));
    q.flush = 1'b1; q.in_valid = 1'b1; q.in_instr = NOP; q.in_pc = 32'h18; q.out_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    q.flush = 1'b0; q.in_valid = 1'b0;
    chk("flush_count", 64'(q.count), 64'(0));
    chk("flush_out_valid", 64'(q.out_valid), 64'(0));
    push(NOP, 32'h1C, mk(32'h1C, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    drain();

    // 5: illegal words
    push(32'hFFFFFFFF, 32'h300, mk(32'h300, 3'b111, 0, 0, 0, 0, 0, CPU5_BRANCHTYPE_NOBRANCH, 4'd0, 3'd0, 1));
    push(32'h02109093, 32'h304, mk(32'h304, 3'b001, 0, 0, 0, 0, 0, CPU5_BRANCHTYPE_NOBRANCH, 4'd0, 3'd0, 1));
    drain();

    // 6: async reset with one entry queued
    q.out_ready = 1'b0;
    push(NOP, 32'h400, mk(32'h400, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    chk("prereset_count", 64'(q.count), 64'(1));
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(q.out_valid), 64'(0));
    chk("async_rst_count", 64'(q.count), 64'(0));
    chk("async_rst_in_ready", 64'(q.in_ready), 64'(1));
    sb.delete();
    @(posedge clk); #1 resetn = 1'b1;
    q.out_ready = 1'b1;
    push(NOP, 32'h500, mk(32'h500, 3'b000, 0, 0, 1, 1, 0, CPU5_BRANCHTYPE_NOBRANCH, CPU5_ALUOP_ADD, CPU5_IMMTYPE_I, 0));
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
